// File: rtl/regfile_pkg.sv
// Shared register-file types: default address width, derived register count
// and the register-index type used across the write-port logic.
package regfile_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int NREGS_DEF  = 2 ** ADDR_W_DEF;

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/onehot_decoder.sv
// Address to one-hot decoder; output is all-zero when en is low.
module onehot_decoder
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0]    addr,
  input  logic                 en,
  output logic [2**ADDR_W-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[addr] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_write_scoreboard.sv
// Register-file write-port decoder with pending-write scoreboard and hazard stall.
// Optional macro ZERO_REG_PROTECT_EN hardwires register 0 (never written, never busy).
module reg_write_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  input  logic [ADDR_W-1:0]    issue_dest,
  input  logic [ADDR_W-1:0]    src_a,
  input  logic [ADDR_W-1:0]    src_b,
  input  logic                 wb_valid,
  input  logic [ADDR_W-1:0]    wb_dest,
  output logic                 stall,
  output logic                 issue_ack,
  output logic [2**ADDR_W-1:0] we_onehot,
  output logic [2**ADDR_W-1:0] busy_vec,
  output logic [ADDR_W:0]      pending_count,
  output logic                 wb_orphan
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(NREGS);

  logic [NREGS-1:0] r_we;
  logic [NREGS-1:0] r_busy;
  logic [ADDR_W:0]  r_cnt;
  logic             r_orphan;

  logic             w_stall;
  logic             w_ack;
  logic             w_wb_en;
  logic             w_iss_en;
  logic             w_orphan_hit;
  logic             w_inc;
  logic             w_dec;
  logic [NREGS-1:0] w_wb_oh;
  logic [NREGS-1:0] w_iss_oh;
  logic [NREGS-1:0] w_busy_nxt;
  logic [ADDR_W:0]  w_cnt_nxt;

  // No bypass: hazard uses only the registered scoreboard.
  assign w_stall = issue_valid
                 & (r_busy[src_a]
                 |  r_busy[src_b]
                 |  r_busy[issue_dest]);
  assign w_ack   = issue_valid & ~w_stall;

`ifdef ZERO_REG_PROTECT_EN
  assign w_wb_en  = wb_valid & (wb_dest != '0);
  assign w_iss_en = w_ack & (issue_dest != '0);
`else
  assign w_wb_en  = wb_valid;
  assign w_iss_en = w_ack;
`endif

  assign w_orphan_hit = w_wb_en & ~r_busy[wb_dest];

  onehot_decoder #(
    .ADDR_W (ADDR_W)
  ) u_wb_dec (
    .addr   (wb_dest),
    .en     (w_wb_en),
    .onehot (w_wb_oh)
  );

  onehot_decoder #(
    .ADDR_W (ADDR_W)
  ) u_iss_dec (
    .addr   (issue_dest),
    .en     (w_iss_en),
    .onehot (w_iss_oh)
  );

  // Set wins over clear when both hit the same register.
  assign w_busy_nxt = (r_busy & ~w_wb_oh) | w_iss_oh;

  assign w_inc = |w_iss_oh;
  assign w_dec = |(w_wb_oh & r_busy & ~w_iss_oh);

  always_comb begin
    w_cnt_nxt = r_cnt;
    unique case (1'b1)
      (w_inc & ~w_dec): begin
        if (r_cnt != CNT_MAX) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      (w_dec & ~w_inc): begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we     <= '0;
      r_busy   <= '0;
      r_cnt    <= '0;
      r_orphan <= 1'b0;
    end else begin
      r_we     <= w_wb_oh;
      r_busy   <= w_busy_nxt;
      r_cnt    <= w_cnt_nxt;
      r_orphan <= r_orphan | w_orphan_hit;
    end
  end

  assign stall         = w_stall;
  assign issue_ack     = w_ack;
  assign we_onehot     = r_we;
  assign busy_vec      = r_busy;
  assign pending_count = r_cnt;
  assign wb_orphan     = r_orphan;

endmodule
